data_sync_pulse: RTL
====================

# data_sync_pulse

Parametrised multi-bit data synchronizer for a single-bit-qualified bus crossing into the CLK domain. A one-bit enable qualifier passes through an NUM_STAGES-deep flop chain. Edge detection on the qualifier produces a single-cycle ENABLE_PULSE, and the bus is captured into SYNC_BUS on that same cycle. The block sits at every multi-bit CDC boundary of the system: register-file to UART config, UART RX data to system controller, and similar crossings.

## Interface
- NUM_STAGES, 2: qualifier synchronizer depth; legal ≥2.
- BUS_WIDTH, 8: data bus width; legal ≥1.
- ENABLE_MODE, 0: 0 = level qualifier (rising edge is an event); 1 = toggle qualifier (any change is an event).
- CNT_WIDTH, 8: event counter width. Present only with DATA_SYNC_EVT_CNT_EN.
- CLK  in  1  destination clock.
- RST  in  1  reset, asynchronous, active-low.
- UNSYNC_BUS  in  BUS_WIDTH  source-domain data, held stable by source (see Timing).
- BUS_ENABLE  in  1  source-domain qualifier, level or toggle per ENABLE_MODE.
- SYNC_BUS  out  BUS_WIDTH  captured data, registered; reset 0.
- ENABLE_PULSE  out  1  one-cycle strobe, high in the cycle SYNC_BUS first shows new data; reset 0.
- CNT_CLR  in  1  synchronous counter clear. Present only with DATA_SYNC_EVT_CNT_EN.
- EVT_CNT  out  CNT_WIDTH  count of ENABLE_PULSE events, registered; reset 0. Present only with DATA_SYNC_EVT_CNT_EN.

## Operation
- Qualifier chain: sync[0] <= BUS_ENABLE, sync[i] <= sync[i-1]. The synchronized qualifier is en_s = sync[NUM_STAGES-1].
- Edge register: en_q <= en_s every cycle.
- Event detection (combinational):
  - ENABLE_MODE 0: evt = en_s & ~en_q.
  - ENABLE_MODE 1: evt = en_s ^ en_q.
- On a cycle with evt: at the next edge, SYNC_BUS <= UNSYNC_BUS and ENABLE_PULSE <= 1.
- On a cycle without evt: SYNC_BUS holds its value and ENABLE_PULSE <= 0.
- UNSYNC_BUS is never sampled except at event capture. No flop on the data path other than SYNC_BUS.
- Level mode:
  - A qualifier held high gives exactly one pulse.
  - The falling edge produces no pulse.
- Toggle mode: both edges produce a pulse each.
- Reset: all chain flops, en_q, SYNC_BUS, ENABLE_PULSE and EVT_CNT clear to 0 asynchronously.
- Reset mid-transfer discards the in-flight event.
- If BUS_ENABLE is 1 at reset release, both modes see a 0→1 change: one pulse NUM_STAGES+1 cycles after the first post-release edge.
- Illegal parameters (NUM_STAGES<2, BUS_WIDTH<1, ENABLE_MODE>1) are rejected at elaboration.

## Timing
- Latency: a BUS_ENABLE change first sampled at edge k gives ENABLE_PULSE=1 and new SYNC_BUS in the cycle after edge k+NUM_STAGES. That is NUM_STAGES+1 edges.
- ENABLE_PULSE width is always exactly 1 CLK cycle.
- Source contract: UNSYNC_BUS must be stable from the BUS_ENABLE change until NUM_STAGES+2 CLK cycles after it.
- Minimum qualifier spacing:
  - Level mode: low ≥ NUM_STAGES+1 cycles and high ≥ NUM_STAGES+1 cycles.
  - Toggle mode: consecutive changes ≥ NUM_STAGES+1 cycles apart.
- Qualifier activity faster than this spacing may merge or drop events. This is not an error condition inside the block.
- Back-to-back events at minimum spacing produce distinct pulses and distinct captures.

## Configuration
- DATA_SYNC_EVT_CNT_EN defined:
  - Adds CNT_CLR, EVT_CNT and CNT_WIDTH.
  - EVT_CNT increments by 1 on each cycle ENABLE_PULSE is high and wraps modulo 2^CNT_WIDTH.
  - CNT_CLR alone sets EVT_CNT to 0 at the next edge.
  - CNT_CLR coincident with ENABLE_PULSE sets EVT_CNT to 1.
- Undefined: ports and counter logic are absent. Core behaviour is identical.

## Structure
- Shared package data_sync_pkg holds:
  - ENABLE_MODE_LEVEL = 0 and ENABLE_MODE_TOGGLE = 1.
  - Defaults for NUM_STAGES and BUS_WIDTH.
- One sub-module, sync_chain (parameter NUM_STAGES): 1-bit flop chain with async active-low reset; output = last stage.
- Edge detect, capture, pulse and counter live in data_sync_pulse.

## Test plan
- Level, basic: NUM_STAGES=2, BUS_WIDTH=8, reset → SYNC_BUS=0x00, ENABLE_PULSE=0. Then UNSYNC_BUS=0xA5 with BUS_ENABLE rising at edge k → ENABLE_PULSE=1 only after edge k+2, SYNC_BUS=0xA5 from then on. Falling BUS_ENABLE → no pulse.
- Latency sweep: NUM_STAGES=2,3,5 → pulse after edges k+2, k+3, k+5 respectively; never earlier.
- Toggle mode: BUS_ENABLE 0→1 with 0x3C, then 1→0 with 0xC3, spaced 4 cycles (NUM_STAGES=2) → two pulses; SYNC_BUS=0x3C then 0xC3.
- Reset: assert RST one cycle after BUS_ENABLE rises → no pulse, SYNC_BUS stays 0.
- Held-high enable: BUS_ENABLE=1 across reset release, UNSYNC_BUS=0x11 → exactly one pulse NUM_STAGES+1 edges after release, SYNC_BUS=0x11.
- Counter (macro on, CNT_WIDTH=2): five events → EVT_CNT 1,2,3,0,1. CNT_CLR on the cycle of a pulse → EVT_CNT=1. Macro off → ports absent, test 1 passes unchanged.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared definitions for the data_sync_pulse CDC block: qualifier modes,
// parameter defaults and the event-detect rule used by the top.
package data_sync_pkg;

    localparam int unsigned ENABLE_MODE_LEVEL  = 0;
    localparam int unsigned ENABLE_MODE_TOGGLE = 1;

    localparam int unsigned DEFAULT_NUM_STAGES = 2;
    localparam int unsigned DEFAULT_BUS_WIDTH  = 8;
    localparam int unsigned DEFAULT_CNT_WIDTH  = 8;

    // Level qualifier: only a rising edge is an event. Toggle: any change.
    function automatic logic detect_event(input logic toggle_mode,
                                          input logic cur,
                                          input logic prev);
        return toggle_mode ? (cur ^ prev) : (cur & ~prev);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer; output is the last stage of the chain.
module sync_chain #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] sync_q;
    logic [NUM_STAGES-1:0] sync_d;

    // Shift the incoming bit one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[NUM_STAGES-2:0], d_i};
    end

    // Chain flops, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_pulse.sv
// Multi-bit bus synchronizer qualified by a single enable bit. The qualifier
// crosses through sync_chain; an edge on the synchronized qualifier captures
// the bus into SYNC_BUS and raises ENABLE_PULSE for one cycle.
// Optional event counter (CNT_CLR / EVT_CNT) is built when
// DATA_SYNC_EVT_CNT_EN is defined.
module data_sync_pulse
    import data_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int unsigned BUS_WIDTH   = DEFAULT_BUS_WIDTH,
    parameter int unsigned ENABLE_MODE = ENABLE_MODE_LEVEL
`ifdef DATA_SYNC_EVT_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE
`ifdef DATA_SYNC_EVT_CNT_EN
    ,
    input  logic                 CNT_CLR,
    output logic [CNT_WIDTH-1:0] EVT_CNT
`endif
);

    // Reject illegal configurations at elaboration.
    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("data_sync_pulse: NUM_STAGES must be >= 2");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("data_sync_pulse: BUS_WIDTH must be >= 1");
    end
    if (ENABLE_MODE > ENABLE_MODE_TOGGLE) begin : g_bad_mode
        $error("data_sync_pulse: ENABLE_MODE must be 0 or 1");
    end

    localparam logic ToggleMode = (ENABLE_MODE == ENABLE_MODE_TOGGLE);

    logic                 en_s;
    logic                 evt;
    logic                 en_q;
    logic                 en_d;
    logic [BUS_WIDTH-1:0] sync_bus_q;
    logic [BUS_WIDTH-1:0] sync_bus_d;
    logic                 pulse_q;
    logic                 pulse_d;

    sync_chain #(
        .NUM_STAGES(NUM_STAGES)
    ) u_sync_chain (
        .CLK(CLK),
        .RST(RST),
        .d_i(BUS_ENABLE),
        .q_o(en_s)
    );

    // Edge detect; the bus is only loaded on an event so it is never
    // sampled while the source may be changing it.
    always_comb begin
        evt        = detect_event(ToggleMode, en_s, en_q);
        en_d       = en_s;
        sync_bus_d = sync_bus_q;
        pulse_d    = 1'b0;
        if (evt) begin
            sync_bus_d = UNSYNC_BUS;
            pulse_d    = 1'b1;
        end
    end

    // Edge register, captured bus and strobe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_q       <= 1'b0;
            sync_bus_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            en_q       <= en_d;
            sync_bus_q <= sync_bus_d;
            pulse_q    <= pulse_d;
        end
    end

    assign SYNC_BUS     = sync_bus_q;
    assign ENABLE_PULSE = pulse_q;

`ifdef DATA_SYNC_EVT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Count strobes; a clear coinciding with a strobe still counts that strobe.
    always_comb begin
        if (CNT_CLR) begin
            cnt_d = CNT_WIDTH'(pulse_q);
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(pulse_q);
        end
    end

    // Event counter register, wraps naturally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign EVT_CNT = cnt_q;
`else
    // No event counter in this build.
`endif

endmodule
